// File: rtl/ball_if.sv
// Paddle-edge inputs, strobes and ball outputs shared between the game logic and the ball engine.
interface ball_if;
  logic        in_ani_stb;
  logic        in_animate;
  logic [11:0] in_lbar_x1, in_lbar_x2, in_lbar_y1, in_lbar_y2;
  logic [11:0] in_rbar_x1, in_rbar_x2, in_rbar_y1, in_rbar_y2;
  logic [11:0] out_x1, out_x2, out_y1, out_y2;
  logic        out_hit, out_score_l, out_score_r;

  modport master (
    output in_ani_stb, in_animate,
    output in_lbar_x1, in_lbar_x2, in_lbar_y1, in_lbar_y2,
    output in_rbar_x1, in_rbar_x2, in_rbar_y1, in_rbar_y2,
    input  out_x1, out_x2, out_y1, out_y2, out_hit, out_score_l, out_score_r
  );

  modport slave (
    input  in_ani_stb, in_animate,
    input  in_lbar_x1, in_lbar_x2, in_lbar_y1, in_lbar_y2,
    input  in_rbar_x1, in_rbar_x2, in_rbar_y1, in_rbar_y2,
    output out_x1, out_x2, out_y1, out_y2, out_hit, out_score_l, out_score_r
  );
endinterface

// File: rtl/ball_ctrl.sv
// Pong ball engine: steps the ball per animation strobe, bounces off walls/paddles,
// scores misses, recentres and re-serves after a strobe-counted delay.
module ball_ctrl #(
  parameter int B_SIZE      = 8,
  parameter int IX          = 320,
  parameter int IY          = 240,
  parameter int SPEED       = 2,
  parameter int D_WIDTH     = 639,
  parameter int D_HEIGHT    = 470,
  parameter int SERVE_DELAY = 60
) (
  input logic   in_clock,
  input logic   in_reset,
  ball_if.slave bus
);
  localparam int          CW  = $clog2(SERVE_DELAY + 1);
  localparam logic [12:0] BS  = 13'(B_SIZE);
  localparam logic [11:0] SP  = 12'(SPEED);
  localparam logic [12:0] DW  = 13'(D_WIDTH);
  localparam logic [12:0] DH  = 13'(D_HEIGHT);
  localparam logic [11:0] X0  = 12'(IX);
  localparam logic [11:0] Y0  = 12'(IY);
  localparam logic [CW-1:0] CLAST = CW'(SERVE_DELAY - 1);

  typedef enum logic [1:0] {SERVE, PLAY, SCORED} state_t;

  state_t        state_q, state_d;
  logic [11:0]   x_q, x_d, y_q, y_d;
  logic          dx_q, dx_d, dy_q, dy_d;   // dx 1 = right, dy 1 = down
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_q, hit_d, scl_q, scl_d, scr_q, scr_d;
  logic          step;

  // 13-bit sums keep every compare addition-only and free of wrap.
  logic [12:0] xe, ye, xb, yb;
  logic        r_ov, l_ov;
  assign xe   = {1'b0, x_q};
  assign ye   = {1'b0, y_q};
  assign xb   = xe + BS;
  assign yb   = ye + BS;
  assign r_ov = (yb >= {1'b0, bus.in_rbar_y1}) && (ye <= {1'b0, bus.in_rbar_y2} + BS);
  assign l_ov = (yb >= {1'b0, bus.in_lbar_y1}) && (ye <= {1'b0, bus.in_lbar_y2} + BS);
  assign step = bus.in_ani_stb & bus.in_animate;

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) state_q <= SERVE;
    else           state_q <= state_d;
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      x_q <= X0; y_q <= Y0; dx_q <= 1'b1; dy_q <= 1'b1; cnt_q <= '0;
      hit_q <= 1'b0; scl_q <= 1'b0; scr_q <= 1'b0;
    end else begin
      x_q <= x_d; y_q <= y_d; dx_q <= dx_d; dy_q <= dy_d; cnt_q <= cnt_d;
      hit_q <= hit_d; scl_q <= scl_d; scr_q <= scr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d = x_q; y_d = y_q; dx_d = dx_q; dy_d = dy_q; cnt_d = cnt_q;
    hit_d = 1'b0; scl_d = 1'b0; scr_d = 1'b0;
    if (step) begin
      case (state_q)
        SERVE: begin
          if (cnt_q == CLAST) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PLAY: begin
          if (dy_q && yb >= DH)       dy_d = 1'b0;
          else if (!dy_q && ye <= BS) dy_d = 1'b1;
          else if (dy_q)              y_d  = y_q + SP;
          else                        y_d  = y_q - SP;

          if (dx_q && xb >= {1'b0, bus.in_rbar_x1} && xe <= {1'b0, bus.in_rbar_x2} + BS && r_ov) begin
            dx_d  = 1'b0;
            hit_d = 1'b1;
          end else if (!dx_q && xe <= {1'b0, bus.in_lbar_x2} + BS && xb >= {1'b0, bus.in_lbar_x1} && l_ov) begin
            dx_d  = 1'b1;
            hit_d = 1'b1;
          end else if (dx_q && xb >= DW) begin
            scl_d = 1'b1; state_d = SCORED; y_d = y_q; dy_d = dy_q;
          end else if (!dx_q && xe <= BS) begin
            scr_d = 1'b1; state_d = SCORED; y_d = y_q; dy_d = dy_q;
          end else if (dx_q) begin
            x_d = x_q + SP;
          end else begin
            x_d = x_q - SP;
          end
        end
        SCORED: begin
          // dx is left as it was at the miss, so the serve heads to the conceding side.
          x_d = X0; y_d = Y0; dy_d = 1'b1;
          cnt_d = '0; state_d = SERVE;
        end
        default: state_d = SERVE;
      endcase
    end
  end

  always_comb begin
    bus.out_x1      = x_q - 12'(B_SIZE);
    bus.out_x2      = x_q + 12'(B_SIZE);
    bus.out_y1      = y_q - 12'(B_SIZE);
    bus.out_y2      = y_q + 12'(B_SIZE);
    bus.out_hit     = hit_q;
    bus.out_score_l = scl_q;
    bus.out_score_r = scr_q;
  end
endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: serve delay, freeze, wall bounce, paddle hit, scoring, async reset.
module tb_ball_ctrl;
  logic in_clock = 1'b0;
  logic in_reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic any_pulse;

  ball_if bif();
  ball_ctrl dut (.in_clock(in_clock), .in_reset(in_reset), .bus(bif.slave));

  always #5 in_clock = ~in_clock;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic strobe();
    @(negedge in_clock); bif.in_ani_stb = 1'b1;
    @(negedge in_clock); bif.in_ani_stb = 1'b0;
    any_pulse = any_pulse | bif.out_hit | bif.out_score_l | bif.out_score_r;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) strobe();
  endtask

  task automatic do_reset();
    @(negedge in_clock); in_reset = 1'b0;
    repeat (2) @(negedge in_clock);
    in_reset = 1'b1;
    @(negedge in_clock);
  endtask

  task automatic clear_bars();
    bif.in_lbar_x1 = 0; bif.in_lbar_x2 = 0; bif.in_lbar_y1 = 0; bif.in_lbar_y2 = 0;
    bif.in_rbar_x1 = 0; bif.in_rbar_x2 = 0; bif.in_rbar_y1 = 0; bif.in_rbar_y2 = 0;
  endtask

  initial begin
    bif.in_ani_stb = 1'b0; bif.in_animate = 1'b1; any_pulse = 1'b0;
    clear_bars();
    repeat (2) @(negedge in_clock);

    // reset state
    chk("rst_x1", bif.out_x1, 312); chk("rst_x2", bif.out_x2, 328);
    chk("rst_y1", bif.out_y1, 232); chk("rst_y2", bif.out_y2, 248);
    chk("rst_pulses", {9'b0, bif.out_hit, bif.out_score_l, bif.out_score_r}, 0);
    in_reset = 1'b1;
    @(negedge in_clock);

    // serve delay then first move
    strobes(60);
    chk("serve_x1", bif.out_x1, 312); chk("serve_y1", bif.out_y1, 232);
    chk("serve_nopulse", {11'b0, any_pulse}, 0);
    strobe();
    chk("first_x1", bif.out_x1, 314); chk("first_y1", bif.out_y1, 234);

    // freeze with in_animate low
    bif.in_animate = 1'b0;
    strobes(20);
    chk("frz_x1", bif.out_x1, 314); chk("frz_y1", bif.out_y1, 234);
    bif.in_animate = 1'b1;
    strobe();
    chk("resume_x1", bif.out_x1, 316); chk("resume_y1", bif.out_y1, 236);

    // bottom wall bounce, then right-wall score
    do_reset();
    strobes(60);
    any_pulse = 1'b0;
    strobes(111);
    chk("bot_y2_111", bif.out_y2, 470);
    strobe();
    chk("bot_y2_112", bif.out_y2, 470);
    strobe();
    chk("bot_y2_113", bif.out_y2, 468);
    strobes(43);
    chk("pre_score_x1", bif.out_x1, 624);
    chk("wall_nopulse", {11'b0, any_pulse}, 0);
    strobe();
    chk("score_l", {11'b0, bif.out_score_l}, 1);
    chk("score_r_quiet", {11'b0, bif.out_score_r}, 0);
    chk("score_x1_hold", bif.out_x1, 624);
    @(negedge in_clock);
    chk("score_l_1cyc", {11'b0, bif.out_score_l}, 0);
    strobe();
    chk("recentre_x1", bif.out_x1, 312); chk("recentre_y1", bif.out_y1, 232);
    strobes(60);
    chk("reserve_hold_x1", bif.out_x1, 312);
    strobe();
    chk("reserve_x1", bif.out_x1, 314); chk("reserve_y1", bif.out_y1, 234);

    // right paddle hit
    do_reset();
    bif.in_rbar_x1 = 619; bif.in_rbar_x2 = 639; bif.in_rbar_y1 = 0; bif.in_rbar_y2 = 470;
    strobes(60);
    strobes(146);
    chk("pre_hit_x1", bif.out_x1, 604);
    strobe();
    chk("hit_pulse", {11'b0, bif.out_hit}, 1);
    chk("hit_x1_hold", bif.out_x1, 604);
    @(negedge in_clock);
    chk("hit_1cyc", {11'b0, bif.out_hit}, 0);
    strobe();
    chk("post_hit_x1", bif.out_x1, 602);
    chk("post_hit_nopulse", {11'b0, bif.out_hit}, 0);

    // asynchronous reset mid-play, between edges
    @(posedge in_clock); #2;
    in_reset = 1'b0;
    #1;
    chk("arst_x1", bif.out_x1, 312); chk("arst_x2", bif.out_x2, 328);
    chk("arst_y1", bif.out_y1, 232); chk("arst_y2", bif.out_y2, 248);
    chk("arst_pulses", {9'b0, bif.out_hit, bif.out_score_l, bif.out_score_r}, 0);
    #10 in_reset = 1'b1;
    clear_bars();
    @(negedge in_clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
- Pong ball engine; sits directly downstream of the two paddle (bar) blocks and consumes their edge coordinates.
- Advances the ball one step per animation strobe and bounces it off the top/bottom walls and both paddles.
- Detects misses past either side wall, emits score pulses, recentres the ball and re-serves after a delay.
- Outputs ball edges in the same 12-bit edge format the paddles use, for the pixel/draw stage.

Parameters:
- B_SIZE, 8, half ball side in pixels.
- IX, 320, initial/serve x of ball centre.
- IY, 240, initial/serve y of ball centre.
- SPEED, 2, pixels moved per strobe on each axis.
- D_WIDTH, 639, display width.
- D_HEIGHT, 470, display height.
- SERVE_DELAY, 60, strobes held at centre before moving (>=1).

Ports:
- in_clock  in  1  base clock.
- in_reset  in  1  asynchronous, active-low reset.
- in_ani_stb  in  1  animation strobe, one in_clock cycle per frame.
- in_animate  in  1  movement and counters advance only while high.
- in_lbar_x1, in_lbar_x2, in_lbar_y1, in_lbar_y2  in  12 each  left paddle edges.
- in_rbar_x1, in_rbar_x2, in_rbar_y1, in_rbar_y2  in  12 each  right paddle edges.
- out_x1, out_x2, out_y1, out_y2  out  12 each  ball edges: x-B_SIZE, x+B_SIZE, y-B_SIZE, y+B_SIZE.
- out_hit  out  1  one-cycle pulse on a paddle bounce.
- out_score_l  out  1  one-cycle pulse: left player scores (ball reached right wall).
- out_score_r  out  1  one-cycle pulse: right player scores (ball reached left wall).

Behaviour:
- Reset (in_reset=0, asynchronous, takes effect immediately, also mid-flight):
  - x=IX, y=IY; dx=right, dy=down; state SERVE; serve counter=0; all pulses 0.
  - Resulting edge outputs at defaults: 312/328/232/248.
- Step: all state updates occur only on in_clock edges with in_ani_stb=1 and in_animate=1. Otherwise all registers hold; pulses are 0 on every cycle except the single cycle following an event strobe.
- SERVE:
  - Counter increments per step.
  - On the step where counter==SERVE_DELAY-1: go to PLAY, clear counter; position unchanged on that step.
- PLAY, evaluated from current registered values each step:
  - Vertical:
    - If dy=down and y+B_SIZE>=D_HEIGHT: dy<=up, y holds.
    - Else if dy=up and y<=B_SIZE: dy<=down, y holds.
    - Otherwise y+=SPEED (down) or y-=SPEED (up).
  - Vertical overlap with a bar means y+B_SIZE>=bar_y1 and y<=bar_y2+B_SIZE. Addition-only compares; no 12-bit underflow.
  - Horizontal, priority paddle > wall > move:
    - dx=right and x+B_SIZE>=rbar_x1 and x<=rbar_x2+B_SIZE and right overlap: dx<=left, x holds, out_hit=1 next cycle.
    - dx=left and x<=lbar_x2+B_SIZE and x+B_SIZE>=lbar_x1 and left overlap: dx<=right, x holds, out_hit=1.
    - Else dx=right and x+B_SIZE>=D_WIDTH: out_score_l=1, state SCORED, x and y hold.
    - Else dx=left and x<=B_SIZE: out_score_r=1, state SCORED.
    - Else x+=SPEED or x-=SPEED.
  - Simultaneous vertical and horizontal events on one step: both apply independently (corner bounce flips dx and dy).
- SCORED, one step:
  - x=IX, y=IY, dy=down.
  - dx points toward the conceding side: right after out_score_l, left after out_score_r.
  - Then state SERVE, counter=0.
- Pulses are registered: high exactly one in_clock cycle, the cycle after the deciding strobe edge.
- in_animate falling mid-serve or mid-play freezes state; resuming continues without loss.

Test Plan:
- Reset, then 60 strobes with in_animate=1 -> edges stay 312/328/232/248, no pulses; strobe 61 -> x=322, y=242.
- In PLAY, hold in_animate=0 for 20 strobes -> edges unchanged; reassert -> next strobe moves by 2 on each axis.
- Bars parked clear (lbar/rbar y1=y2=0), 111 play strobes -> y=462 (y2=470); strobe 112 -> y holds, dy=up; strobe 113 -> y=460.
- rbar x1=619, x2=639, y1=0, y2=470 -> after 146 play strobes x=612; strobe 147 -> out_hit one cycle, x holds; strobe 148 -> x=610.
- Bars parked clear -> after 156 play strobes x=632; strobe 157 -> out_score_l one cycle; next strobe -> x=320, y=240, SERVE; 60 strobes later ball moves right.
- Drive in_reset low asynchronously mid-play, between clock edges -> outputs return to 312/328/232/248 before the next in_clock edge; pulses 0.
